psram_xfer: RTL and testbench

PSRAM_XFER -- requirements
Module: psram_xfer

---
 rtl/psram_xfer.sv | 178 +++++++++++++++++
 tb/tb_psram_xfer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/psram_xfer.sv
// Quad-SPI PSRAM transaction engine: one command/address/data burst per accepted request.
// Optional completion interrupt is built when PSRAM_XFER_IRQ_EN is defined.
`timescale 1ns/1ps
module psram_xfer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [19:0] div_i,
  input  logic [3:0]  dummy_i,
  input  logic        irq_en_i,
  input  logic        xfer_valid_i,
  output logic        xfer_ready_o,
  input  logic        xfer_we_i,
  input  logic [7:0]  xfer_cmd_i,
  input  logic [23:0] xfer_addr_i,
  input  logic [31:0] xfer_wdata_i,
  output logic [31:0] xfer_rdata_o,
  output logic        xfer_rvalid_o,
  output logic        psram_sck_o,
  output logic        psram_ce_o,
  output logic [3:0]  psram_io_en_o,
  output logic [3:0]  psram_io_out_o,
  input  logic [3:0]  psram_io_in_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_END
  } state_t;

  state_t      state;
  logic [18:0] half_q;
  logic [18:0] hcnt;
  logic [3:0]  dummy_q;
  logic [3:0]  nib;
  logic        we_q;
  logic [63:0] out_sh;
  logic [31:0] rd_sh;
  logic [3:0]  last_nib;
  logic [18:0] half_in;
  logic        accept;
  logic        tick;
  logic        active;
  logic        rise;
  logic        fall;

  // Divider with bit 0 dropped; a zero half-period is clamped to one clk
  assign half_in = (div_i[19:1] == 19'd0) ? 19'd1 : div_i[19:1];
  assign accept  = xfer_valid_i && xfer_ready_o;
  assign tick    = (hcnt == half_q - 19'd1);
  assign active  = (state != S_IDLE) && (state != S_END);
  assign rise    = active && tick && !psram_sck_o;
  assign fall    = active && tick && psram_sck_o;

`ifdef PSRAM_XFER_IRQ_EN
  logic unused_div0;
  assign unused_div0 = div_i[0];
`else
  logic unused_bits;
  assign unused_bits = div_i[0] ^ irq_en_i;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    last_nib = 4'd7;
    case (state)
      S_CMD:   last_nib = 4'd1;
      S_ADDR:  last_nib = 4'd5;
      S_DUMMY: last_nib = dummy_q - 4'd1;
      default: last_nib = 4'd7;
    endcase
  end

  // Data shifters carry no reset; they are always reloaded before use
  always_ff @(posedge clk_i) begin
    if (accept)
      out_sh <= {xfer_cmd_i, xfer_addr_i, xfer_wdata_i};
    else if (fall)
      out_sh <= {out_sh[59:0], 4'h0};
    if (rise && state == S_RDATA)
      rd_sh <= {rd_sh[27:0], psram_io_in_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      half_q         <= 19'd1;
      hcnt           <= 19'd0;
      dummy_q        <= 4'd0;
      nib            <= 4'd0;
      we_q           <= 1'b0;
      xfer_ready_o   <= 1'b1;
      xfer_rdata_o   <= 32'd0;
      xfer_rvalid_o  <= 1'b0;
      psram_sck_o    <= 1'b0;
      psram_ce_o     <= 1'b1;
      psram_io_en_o  <= 4'h0;
      psram_io_out_o <= 4'h0;
`ifdef PSRAM_XFER_IRQ_EN
      irq_o          <= 1'b0;
`endif
    end else begin
      xfer_rvalid_o <= 1'b0;
`ifdef PSRAM_XFER_IRQ_EN
      irq_o         <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            state          <= S_CMD;
            xfer_ready_o   <= 1'b0;
            psram_ce_o     <= 1'b0;
            psram_sck_o    <= 1'b0;
            psram_io_en_o  <= 4'hF;
            psram_io_out_o <= xfer_cmd_i[7:4];
            half_q         <= half_in;
            dummy_q        <= dummy_i;
            we_q           <= xfer_we_i;
            hcnt           <= 19'd0;
            nib            <= 4'd0;
          end
        end
        S_END: begin
          if (tick) begin
            state        <= S_IDLE;
            xfer_ready_o <= 1'b1;
            hcnt         <= 19'd0;
          end else begin
            hcnt <= hcnt + 19'd1;
          end
        end
        default: begin
          if (!tick) begin
            hcnt <= hcnt + 19'd1;
          end else begin
            hcnt        <= 19'd0;
            psram_sck_o <= ~psram_sck_o;
            // A falling SCK closes one period: present the next nibble, maybe change phase
            if (psram_sck_o) begin
              psram_io_out_o <= out_sh[59:56];
              if (nib == last_nib) begin
                nib <= 4'd0;
                case (state)
                  S_CMD:  state <= S_ADDR;
                  S_ADDR: begin
                    if (we_q) begin
                      state <= S_WDATA;
                    end else begin
                      state          <= (dummy_q != 4'd0) ? S_DUMMY : S_RDATA;
                      psram_io_en_o  <= 4'h0;
                      psram_io_out_o <= 4'h0;
                    end
                  end
                  S_DUMMY: state <= S_RDATA;
                  default: begin
                    state          <= S_END;
                    psram_ce_o     <= 1'b1;
                    psram_io_en_o  <= 4'h0;
                    psram_io_out_o <= 4'h0;
                    if (state == S_RDATA) begin
                      xfer_rdata_o  <= rd_sh;
                      xfer_rvalid_o <= 1'b1;
                    end
`ifdef PSRAM_XFER_IRQ_EN
                    irq_o <= irq_en_i;
`endif
                  end
                endcase
              end else begin
                nib <= nib + 4'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_xfer.sv
// Directed bench for psram_xfer: bus monitor, simple PSRAM read responder, hand-computed vectors.
`timescale 1ns/1ps
module tb_psram_xfer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [19:0] div_i;
  logic [3:0]  dummy_i;
  logic        irq_en_i;
  logic        xfer_valid_i;
  logic        xfer_ready_o;
  logic        xfer_we_i;
  logic [7:0]  xfer_cmd_i;
  logic [23:0] xfer_addr_i;
  logic [31:0] xfer_wdata_i;
  logic [31:0] xfer_rdata_o;
  logic        xfer_rvalid_o;
  logic        psram_sck_o;
  logic        psram_ce_o;
  logic [3:0]  psram_io_en_o;
  logic [3:0]  psram_io_out_o;
  logic [3:0]  psram_io_in_i = 4'h0;
  logic        irq_o;

`ifdef PSRAM_XFER_IRQ_EN
  localparam int IRQ_PER = 1;
`else
  localparam int IRQ_PER = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  int          rises, en_rises, en0_rises, ce_low, rv_cnt, irq_cnt, falls, gap;
  int          dummy_cur;
  int          k;
  logic [63:0] out_word;
  logic [31:0] en_word;
  logic [31:0] rd_word;
  logic        prev_sck = 1'b0;
  logic        prev_ce  = 1'b1;

  psram_xfer dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .div_i          (div_i),
    .dummy_i        (dummy_i),
    .irq_en_i       (irq_en_i),
    .xfer_valid_i   (xfer_valid_i),
    .xfer_ready_o   (xfer_ready_o),
    .xfer_we_i      (xfer_we_i),
    .xfer_cmd_i     (xfer_cmd_i),
    .xfer_addr_i    (xfer_addr_i),
    .xfer_wdata_i   (xfer_wdata_i),
    .xfer_rdata_o   (xfer_rdata_o),
    .xfer_rvalid_o  (xfer_rvalid_o),
    .psram_sck_o    (psram_sck_o),
    .psram_ce_o     (psram_ce_o),
    .psram_io_en_o  (psram_io_en_o),
    .psram_io_out_o (psram_io_out_o),
    .psram_io_in_i  (psram_io_in_i),
    .irq_o          (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Observe the bus on the falling clk edge; the responder presents the next read nibble after each SCK rise
  always @(negedge clk_i) begin
    if (psram_sck_o && !prev_sck) begin
      rises++;
      out_word = {out_word[59:0], psram_io_out_o};
      if (psram_io_en_o == 4'hF) begin
        en_rises++;
        en_word = {en_word[27:0], psram_io_out_o};
      end else if (psram_io_en_o == 4'h0) begin
        en0_rises++;
      end
      k = rises - 8 - dummy_cur;
      psram_io_in_i = (k >= 0 && k < 8) ? rd_word[31-4*k -: 4] : 4'h0;
    end
    if (!psram_ce_o) ce_low++;
    if (!psram_ce_o && prev_ce) falls++;
    if (psram_ce_o && falls == 1) gap++;
    if (xfer_rvalid_o) rv_cnt++;
    if (irq_o) irq_cnt++;
    prev_sck = psram_sck_o;
    prev_ce  = psram_ce_o;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    #1;
    rises = 0; en_rises = 0; en0_rises = 0; ce_low = 0; rv_cnt = 0;
    irq_cnt = 0; falls = 0; gap = 0; out_word = 64'd0; en_word = 32'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!(xfer_ready_o && psram_ce_o) && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, (n < 5000), 1'b1);
  endtask

  task automatic xfer(input logic we, input logic [7:0] cmd, input logic [23:0] addr,
                      input logic [31:0] wd, input logic [19:0] div, input logic [3:0] dmy,
                      input logic [31:0] rword, input string tag);
    clear_mon();
    rd_word   = rword;
    dummy_cur = dmy;
    @(negedge clk_i);
    div_i = div; dummy_i = dmy; xfer_we_i = we;
    xfer_cmd_i = cmd; xfer_addr_i = addr; xfer_wdata_i = wd;
    xfer_valid_i = 1'b1;
    @(negedge clk_i);
    xfer_valid_i = 1'b0;
    // Configuration changes after acceptance must not affect the running transfer
    div_i   = 20'hFFFFE;
    dummy_i = 4'hF;
    wait_idle(tag);
  endtask

  initial begin
    rst_n_i = 1'b0; div_i = 20'd2; dummy_i = 4'd0; irq_en_i = 1'b1;
    xfer_valid_i = 1'b0; xfer_we_i = 1'b0; xfer_cmd_i = 8'h00;
    xfer_addr_i = 24'h0; xfer_wdata_i = 32'h0; rd_word = 32'h0; dummy_cur = 0;
    clear_mon();
    repeat (3) @(negedge clk_i);
    check("rst_sck",    psram_sck_o,    1'b0);
    check("rst_ce",     psram_ce_o,     1'b1);
    check("rst_io_en",  psram_io_en_o,  4'h0);
    check("rst_io_out", psram_io_out_o, 4'h0);
    check("rst_ready",  xfer_ready_o,   1'b1);
    check("rst_rvalid", xfer_rvalid_o,  1'b0);
    check("rst_rdata",  xfer_rdata_o,   32'd0);
    check("rst_irq",    irq_o,          1'b0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Write, divider 2
    xfer(1'b1, 8'h38, 24'h123456, 32'hDEADBEEF, 20'd2, 4'd0, 32'h0, "wr_done");
    check("wr_nibbles", out_word, 64'h38123456DEADBEEF);
    check("wr_rises",   rises,    16);
    check("wr_en_f",    en_rises, 16);
    check("wr_ce_low",  ce_low,   32);
    check("wr_rvalid",  rv_cnt,   0);
    check("wr_irq",     irq_cnt,  IRQ_PER);

    // Read, divider 4, six dummy cycles
    xfer(1'b0, 8'hEB, 24'h000100, 32'h0, 20'd4, 4'd6, 32'hCAFEF00D, "rd_done");
    check("rd_cmd_addr", en_word,      32'hEB000100);
    check("rd_en_f",     en_rises,     8);
    check("rd_en_0",     en0_rises,    14);
    check("rd_data",     xfer_rdata_o, 32'hCAFEF00D);
    check("rd_rvalid",   rv_cnt,       1);
    check("rd_ce_low",   ce_low,       88);
    check("rd_irq",      irq_cnt,      IRQ_PER);

    // Divider 0 clamps to 2; interrupt disabled; read data held across a write
    irq_en_i = 1'b0;
    xfer(1'b1, 8'h02, 24'hABCDEF, 32'h01234567, 20'd0, 4'd0, 32'h0, "d0_done");
    check("d0_ce_low",  ce_low,       32);
    check("d0_nibbles", out_word,     64'h02ABCDEF01234567);
    check("d0_irq_off", irq_cnt,      0);
    check("rdata_hold", xfer_rdata_o, 32'hCAFEF00D);
    irq_en_i = 1'b1;

    // Divider 5 behaves as 4; zero dummy skips the wait phase
    xfer(1'b0, 8'h6B, 24'hFEDCBA, 32'h0, 20'd5, 4'd0, 32'h5A5AA5A5, "d5_done");
    check("d5_ce_low", ce_low,       64);
    check("d5_en_0",   en0_rises,    8);
    check("d5_data",   xfer_rdata_o, 32'h5A5AA5A5);
    check("d5_rvalid", rv_cnt,       1);

    // Reset asserted during the address phase
    clear_mon();
    rd_word = 32'h11111111; dummy_cur = 2;
    @(negedge clk_i);
    div_i = 20'd4; dummy_i = 4'd2; xfer_we_i = 1'b0; xfer_cmd_i = 8'hEB;
    xfer_addr_i = 24'h000040; xfer_valid_i = 1'b1;
    @(negedge clk_i);
    xfer_valid_i = 1'b0;
    for (int n = 0; n < 500 && rises < 4; n++) @(negedge clk_i);
    check("mid_in_addr", rises, 4);
    #2 rst_n_i = 1'b0;
    #1;
    check("mid_ce",     psram_ce_o,    1'b1);
    check("mid_sck",    psram_sck_o,   1'b0);
    check("mid_ready",  xfer_ready_o,  1'b1);
    check("mid_io_en",  psram_io_en_o, 4'h0);
    check("mid_rdata",  xfer_rdata_o,  32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (100) @(negedge clk_i);
    check("mid_no_rvalid", rv_cnt,  0);
    check("mid_no_irq",    irq_cnt, 0);

    xfer(1'b0, 8'hEB, 24'h000040, 32'h0, 20'd2, 4'd1, 32'h13579BDF, "post_done");
    check("post_data",   xfer_rdata_o, 32'h13579BDF);
    check("post_ce_low", ce_low,       34);
    check("post_rvalid", rv_cnt,       1);

    // Back-to-back requests with valid held high
    clear_mon();
    @(negedge clk_i);
    div_i = 20'd2; dummy_i = 4'd0; xfer_we_i = 1'b1; xfer_cmd_i = 8'h38;
    xfer_addr_i = 24'h000000; xfer_wdata_i = 32'h0; xfer_valid_i = 1'b1;
    for (int n = 0; n < 1000 && falls < 2; n++) @(negedge clk_i);
    xfer_valid_i = 1'b0;
    wait_idle("b2b_done");
    check("b2b_count",  falls,       2);
    check("b2b_gap",    (gap >= 1),  1'b1);
    check("b2b_ce_low", ce_low,      64);
    check("b2b_irq",    irq_cnt,     2 * IRQ_PER);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
